// File: rtl/wb_b3_mem_arbiter.sv
// Two-master Wishbone B3 arbiter in front of a single memory slave; grants whole cycles, round-robin on contention.
// Define WB_ARB_WATCHDOG_EN to add a stall watchdog that errors the owner and drains the bus.
module wb_b3_mem_arbiter #(
  parameter int AW             = 27,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic            m0_cab_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic            m1_cab_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic            s_cab_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [1:0]      owner_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end

  // Encoding doubles as the owner_o debug value.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
`ifdef WB_ARB_WATCHDOG_EN
    , DRAIN = 2'b11
`endif
  } state_t;

  state_t state, state_nxt;
  logic   last_owner;
  logic   wd_fire;

`ifdef WB_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      wd_cnt <= '0;
    else if (!s_stb_o || s_ack_i || s_err_i || s_rty_i)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 16'd1;
  end

  assign wd_fire = s_stb_o && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == OWN0)
        last_owner <= 1'b0;
      else if (state == IDLE && state_nxt == OWN1)
        last_owner <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_owner))
          state_nxt = OWN0;
        else if (m1_cyc_i)
          state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i)
          state_nxt = IDLE;
`ifdef WB_ARB_WATCHDOG_EN
        else if (wd_fire)
          state_nxt = DRAIN;
`endif
      end
      OWN1: begin
        if (!m1_cyc_i)
          state_nxt = IDLE;
`ifdef WB_ARB_WATCHDOG_EN
        else if (wd_fire)
          state_nxt = DRAIN;
`endif
      end
`ifdef WB_ARB_WATCHDOG_EN
      // last_owner still names the master that timed out.
      DRAIN: begin
        if (!(last_owner ? m1_cyc_i : m0_cyc_i))
          state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_cab_o  = 1'b0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    if (state == OWN0) begin
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      s_sel_o  = m0_sel_i;
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_cab_o  = m0_cab_i;
      s_cti_o  = m0_cti_i;
      s_bte_o  = m0_bte_i;
      m0_ack_o = s_ack_i && !rst;
      m0_err_o = (s_err_i || wd_fire) && !rst;
      m0_rty_o = s_rty_i && !rst;
    end else if (state == OWN1) begin
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      s_sel_o  = m1_sel_i;
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_cab_o  = m1_cab_i;
      s_cti_o  = m1_cti_i;
      s_bte_o  = m1_bte_i;
      m1_ack_o = s_ack_i && !rst;
      m1_err_o = (s_err_i || wd_fire) && !rst;
      m1_rty_o = s_rty_i && !rst;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign owner_o  = state;

endmodule

// File: tb/tb_wb_b3_mem_arbiter.sv
// Randomized and directed bench for wb_b3_mem_arbiter against a cycle-level ownership model.
module tb_wb_b3_mem_arbiter;
  localparam int AW  = 27;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;
`ifdef WB_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk, rst;
  logic [AW-1:0] m0_adr, m1_adr, s_adr_o;
  logic [DW-1:0] m0_dat, m1_dat, s_dat_o, m0_dat_o, m1_dat_o, s_dat;
  logic [SW-1:0] m0_sel, m1_sel, s_sel_o;
  logic m0_cyc, m0_stb, m0_we, m0_cab, m1_cyc, m1_stb, m1_we, m1_cab;
  logic [2:0] m0_cti, m1_cti, s_cti_o;
  logic [1:0] m0_bte, m1_bte, s_bte_o, owner_o;
  logic m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_cab_o, s_ack, s_err, s_rty;

  int n_vec = 0, n_bad = 0;
  int mo, ml, ms;
  int m0_acks = 0, m1_acks = 0, m0_errs = 0;

  wb_b3_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_cyc_i(m0_cyc),
    .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_cab_i(m0_cab), .m0_cti_i(m0_cti),
    .m0_bte_i(m0_bte), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m0_dat_o(m0_dat_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_cyc_i(m1_cyc),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_cab_i(m1_cab), .m1_cti_i(m1_cti),
    .m1_bte_i(m1_bte), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .m1_dat_o(m1_dat_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cab_o(s_cab_o), .s_cti_o(s_cti_o),
    .s_bte_o(s_bte_o), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .s_dat_i(s_dat), .owner_o(owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] bus_of(input logic [AW-1:0] a, input logic [DW-1:0] d,
      input logic [SW-1:0] sl, input logic cy, input logic st, input logic we,
      input logic cb, input logic [2:0] ct, input logic [1:0] bt);
    return 128'({a, d, sl, cy, st, we, cb, ct, bt});
  endfunction

  // Check the cycle's outputs against the model, then let the clock edge advance the model.
  task automatic cycle();
    logic o0, o1, own_stb, term, fire;
    logic [127:0] exp_bus;
    #1;
    o0      = (mo == 1);
    o1      = (mo == 2);
    own_stb = (o0 && m0_stb) || (o1 && m1_stb);
    term    = s_ack || s_err || s_rty;
    fire    = WD && own_stb && (ms == TMO - 1);
    exp_bus = o0 ? bus_of(m0_adr, m0_dat, m0_sel, m0_cyc, m0_stb, m0_we, m0_cab, m0_cti, m0_bte) :
              o1 ? bus_of(m1_adr, m1_dat, m1_sel, m1_cyc, m1_stb, m1_we, m1_cab, m1_cti, m1_bte) : '0;
    chk("owner", 128'(owner_o), 128'(mo));
    chk("s_bus", bus_of(s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cab_o, s_cti_o, s_bte_o), exp_bus);
    chk("m0_term", 128'({m0_ack_o, m0_err_o, m0_rty_o}), (o0 && !rst) ? 128'({s_ack, s_err || fire, s_rty}) : 128'(0));
    chk("m1_term", 128'({m1_ack_o, m1_err_o, m1_rty_o}), (o1 && !rst) ? 128'({s_ack, s_err || fire, s_rty}) : 128'(0));
    chk("dat_o", 128'({m0_dat_o, m1_dat_o}), 128'({s_dat, s_dat}));
    m0_acks += int'(m0_ack_o);
    m1_acks += int'(m1_ack_o);
    m0_errs += int'(m0_err_o);
    @(posedge clk);
    if (rst) begin
      mo = 0; ml = 1; ms = 0;
    end else begin
      case (mo)
        0: if (m0_cyc && (!m1_cyc || ml == 1)) begin mo = 1; ml = 0; end
           else if (m1_cyc) begin mo = 2; ml = 1; end
        1: if (!m0_cyc) mo = 0; else if (fire) mo = 3;
        2: if (!m1_cyc) mo = 0; else if (fire) mo = 3;
        default: if (!(ml == 1 ? m1_cyc : m0_cyc)) mo = 0;
      endcase
      ms = (!own_stb || term) ? 0 : ms + 1;
    end
    #1;
  endtask

  task automatic idle_all();
    {m0_adr, m0_dat, m0_sel, m0_cyc, m0_stb, m0_we, m0_cab, m0_cti, m0_bte} = '0;
    {m1_adr, m1_dat, m1_sel, m1_cyc, m1_stb, m1_we, m1_cab, m1_cti, m1_bte} = '0;
    {s_ack, s_err, s_rty} = '0;
    s_dat = 32'h1234_5678;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int a0, e0, err_at;
    mo = 0; ml = 1; ms = 0;
    idle_all();
    do_reset();
    cycle();

    // single write from m0
    m0_adr = 27'h100; m0_dat = 32'hDEAD_BEEF; m0_sel = 4'hF;
    m0_cyc = 1; m0_stb = 1; m0_we = 1;
    a0 = m1_acks; e0 = m0_acks;
    cycle();
    chk("wr_latency", 128'(s_cyc_o), 128'(1));
    s_ack = 1;
    cycle();
    idle_all();
    cycle();
    chk("wr_m0_acks", 128'(m0_acks - e0), 128'(1));
    chk("wr_m1_acks", 128'(m1_acks - a0), 128'(0));

    // simultaneous request straight out of reset
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    cycle();
    chk("sim_first", 128'(owner_o), 128'(1));
    m0_cyc = 0; m0_stb = 0;
    cycle();
    chk("sim_gap", 128'(owner_o), 128'(0));
    cycle();
    chk("sim_second", 128'(owner_o), 128'(2));
    idle_all();
    cycle();

    // m1 burst with m0 requesting mid-burst
    m1_cyc = 1; m1_stb = 1; m1_cti = 3'b010; m1_cab = 1;
    cycle();
    for (int b = 0; b < 8; b++) begin
      m1_adr = 27'(32'h200 + 4 * b);
      m1_cti = (b == 7) ? 3'b111 : 3'b010;
      s_ack = 1;
      if (b == 2) begin m0_cyc = 1; m0_stb = 1; end
      chk("burst_hold", 128'(owner_o), 128'(2));
      cycle();
    end
    m1_cyc = 0; m1_stb = 0; m1_cab = 0; m1_cti = 0; s_ack = 0;
    cycle();
    chk("burst_gap", 128'(owner_o), 128'(0));
    cycle();
    chk("burst_handover", 128'(owner_o), 128'(1));
    idle_all();
    cycle();

    // round robin with both masters always requesting
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    cycle();
    for (int k = 0; k < 8; k++) begin
      chk("rr_grant", 128'(owner_o), 128'((k % 2 == 0) ? 1 : 2));
      s_ack = 1;
      cycle();
      s_ack = 0;
      if (k % 2 == 0) begin m0_cyc = 0; m0_stb = 0; end
      else begin m1_cyc = 0; m1_stb = 0; end
      cycle();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      cycle();
    end
    idle_all();
    cycle();
    cycle();

    // reset in the middle of an m0 burst
    m0_cyc = 1; m0_stb = 1; m0_cti = 3'b010; s_ack = 1;
    cycle();
    for (int b = 0; b < 3; b++) cycle();
    rst = 1;
    e0 = m0_acks; a0 = m1_acks + m0_errs;
    cycle();
    chk("rst_cyc", 128'(s_cyc_o), 128'(0));
    chk("rst_owner", 128'(owner_o), 128'(0));
    chk("rst_no_term", 128'(m0_acks - e0 + m1_acks + m0_errs - a0), 128'(0));
    rst = 0;
    idle_all();
    cycle();

    // slave that never answers
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    cycle();
    e0 = m0_errs; err_at = 0;
    for (int i = 1; i <= (WD ? 20 : 40); i++) begin
      a0 = m0_errs;
      cycle();
      if (m0_errs != a0 && err_at == 0) err_at = i;
    end
`ifdef WB_ARB_WATCHDOG_EN
    chk("wd_err_count", 128'(m0_errs - e0), 128'(1));
    chk("wd_err_cycle", 128'(err_at), 128'(16));
    chk("wd_drain", 128'(owner_o), 128'(3));
    m0_cyc = 0; m0_stb = 0;
    cycle();
    chk("wd_release", 128'(owner_o), 128'(0));
`else
    chk("stall_no_err", 128'(m0_errs - e0), 128'(0));
    chk("stall_hold", 128'(owner_o), 128'(1));
    m0_cyc = 0; m0_stb = 0;
    cycle();
    chk("stall_release", 128'(owner_o), 128'(0));
`endif
    idle_all();
    cycle();

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (m0_cyc) m0_cyc = ($urandom % 6) != 0; else m0_cyc = ($urandom % 3) == 0;
      if (m1_cyc) m1_cyc = ($urandom % 6) != 0; else m1_cyc = ($urandom % 3) == 0;
      m0_stb = m0_cyc && (($urandom % 4) != 0);
      m1_stb = m1_cyc && (($urandom % 4) != 0);
      m0_adr = AW'($urandom); m1_adr = AW'($urandom);
      m0_dat = $urandom; m1_dat = $urandom; s_dat = $urandom;
      m0_sel = SW'($urandom); m1_sel = SW'($urandom);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_cab = 1'($urandom); m1_cab = 1'($urandom);
      m0_cti = 3'($urandom); m1_cti = 3'($urandom);
      m0_bte = 2'($urandom); m1_bte = 2'($urandom);
      s_ack = ($urandom % 3) == 0;
      s_err = ($urandom % 16) == 0;
      s_rty = ($urandom % 16) == 0;
      rst   = ($urandom % 256) == 0;
      cycle();
    end
    rst = 0;
    idle_all();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
